// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction between EXE and WB, waits for the data
// SRAM response, buffers early read data and drops responses owed to flushed loads.
`timescale 1ns/1ps
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 81,
  parameter int MS_TO_WS_BUS_WD = 72
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [39:0]                ms_forward,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  output logic                       ms_ex
);

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;
  logic                       r_buf_valid;
  logic [31:0]                r_buf_data;
  logic [1:0]                 r_cancel_cnt;

  logic [31:0] w_pc;
  logic        w_ld_b, w_ld_h, w_ld_w, w_ld_bu, w_ld_hu;
  logic [4:0]  w_dest;
  logic        w_rf_we, w_res_from_mem, w_bus_req_sent;
  logic [1:0]  w_addr_lo;
  logic [31:0] w_result;
  logic        w_excp, w_ertn;

  assign w_pc           = r_bus[80:49];
  assign w_ld_b         = r_bus[48];
  assign w_ld_h         = r_bus[47];
  assign w_ld_w         = r_bus[46];
  assign w_ld_bu        = r_bus[45];
  assign w_ld_hu        = r_bus[44];
  assign w_dest         = r_bus[43:39];
  assign w_rf_we        = r_bus[38];
  assign w_res_from_mem = r_bus[37];
  assign w_bus_req_sent = r_bus[36];
  assign w_addr_lo      = r_bus[35:34];
  assign w_result       = r_bus[33:2];
  assign w_excp         = r_bus[1];
  assign w_ertn         = r_bus[0];

  // Exception/ertn entries never issued a request, whatever EXE reported.
  logic w_mem_req_sent;
  logic w_resp_hit;
  logic w_ready_go;
  logic w_leave;
  logic w_buf_fill;
  logic w_cancel_inc;
  logic w_cancel_dec;
  logic [1:0] w_cancel_cnt_next;

  assign w_mem_req_sent = w_bus_req_sent & ~w_excp & ~w_ertn;
  assign w_resp_hit     = data_sram_data_ok & (r_cancel_cnt == 2'd0);
  assign w_ready_go     = ~w_mem_req_sent | r_buf_valid | w_resp_hit;
  assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin) | flush;
  assign ms_to_ws_valid = r_ms_valid & w_ready_go & ~flush;
  assign w_leave        = ms_to_ws_valid & ws_allowin;
  assign w_buf_fill     = w_resp_hit & r_ms_valid & w_mem_req_sent & ~r_buf_valid & ~ws_allowin;
  assign ms_ex          = r_ms_valid & (w_excp | w_ertn);

  assign w_cancel_inc = flush & r_ms_valid & w_mem_req_sent & ~r_buf_valid & ~w_resp_hit;
  assign w_cancel_dec = data_sram_data_ok & (r_cancel_cnt != 2'd0);

  always_comb begin
    w_cancel_cnt_next = r_cancel_cnt;
    if (w_cancel_inc && !w_cancel_dec) begin
      w_cancel_cnt_next = (r_cancel_cnt == 2'd3) ? 2'd3 : r_cancel_cnt + 2'd1;
    end else if (w_cancel_dec && !w_cancel_inc) begin
      w_cancel_cnt_next = r_cancel_cnt - 2'd1;
    end
  end

  // Load data path: buffered word wins over the live SRAM bus.
  logic [31:0] w_ld_word;
  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_final_result;

  assign w_ld_word = r_buf_valid ? r_buf_data : data_sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = w_ld_word[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[w_addr_lo];
  assign w_half = w_addr_lo[1] ? w_ld_word[31:16] : w_ld_word[15:0];

  always_comb begin
    w_load_ext = w_ld_word;
    if (w_ld_b) begin
      w_load_ext = {{24{w_byte[7]}}, w_byte};
    end else if (w_ld_bu) begin
      w_load_ext = {24'd0, w_byte};
    end else if (w_ld_h) begin
      w_load_ext = {{16{w_half[15]}}, w_half};
    end else if (w_ld_hu) begin
      w_load_ext = {16'd0, w_half};
    end else if (w_ld_w) begin
      w_load_ext = w_ld_word;
    end
  end

  assign w_final_result = w_res_from_mem ? w_load_ext : w_result;

  assign ms_to_ws_bus = {w_pc, w_dest, w_rf_we, w_final_result, w_excp, w_ertn};
  assign ms_forward   = {r_ms_valid, w_rf_we, w_dest, w_final_result,
                         r_ms_valid & w_res_from_mem & ~w_ready_go};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid   <= 1'b0;
      r_bus        <= '0;
      r_buf_valid  <= 1'b0;
      r_buf_data   <= 32'd0;
      r_cancel_cnt <= 2'd0;
    end else begin
      if (flush) begin
        r_ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin && !flush) begin
        r_bus <= es_to_ms_bus;
      end
      if (w_leave || flush) begin
        r_buf_valid <= 1'b0;
      end else if (w_buf_fill) begin
        r_buf_valid <= 1'b1;
      end
      if (w_buf_fill) begin
        r_buf_data <= data_sram_rdata;
      end
      r_cancel_cnt <= w_cancel_cnt_next;
    end
  end

endmodule
